// File: rtl/uart_packet_demux.sv
// uart_packet_demux: 8N1 UART receiver feeding an addr/count/payload packet
// parser. Each payload byte comes out on data/addr with a one-cycle write strobe.
module uart_packet_demux #(
    parameter int unsigned CLKS_PER_BIT = 186,
    parameter int unsigned TIMEOUT_CLKS = 2097152
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] data,
    output logic [7:0] addr,
    output logic       write,
    output logic       error,
    output logic [1:0] state
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_ADDR = 2'd0, P_COUNT = 2'd1, P_DATA = 2'd2} p_state_t;

    logic            rxd_s1_q, rxd_s2_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid, frame_err;

    p_state_t        pstate_q, pstate_d;
    logic [7:0]      addr_q, addr_d, data_q, data_d, remaining_q, remaining_d;
    logic            write_q, write_d, error_q, error_d;
    logic [31:0]     idle_cnt_q, idle_cnt_d;
    logic            timeout;

    // two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= uart_rxd;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    // receiver next-state: start bit checked mid-bit, then one sample per bit time
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxd_s2_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = CW'(CLKS_PER_BIT / 2 - 1);
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rxd_s2_q) begin
                        rx_state_d = RX_BITS;
                        cnt_d      = CW'(CLKS_PER_BIT - 1);
                        bit_d      = 3'd0;
                    end else begin
                        rx_state_d = RX_IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_BITS: begin
                if (cnt_q == '0) begin
                    shift_d = {rxd_s2_q, shift_q[7:1]};   // LSB first
                    cnt_d   = CW'(CLKS_PER_BIT - 1);
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    else               bit_d      = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin   // RX_STOP
                if (cnt_q == '0) begin
                    if (rxd_s2_q) byte_valid = 1'b1;
                    else          frame_err  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // receiver state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    assign timeout = (TIMEOUT_CLKS != 0) && (pstate_q != P_ADDR) &&
                     (idle_cnt_q == TIMEOUT_CLKS - 1);

    // parser next-state: framing error beats a byte, a byte beats a timeout
    always_comb begin
        pstate_d    = pstate_q;
        addr_d      = addr_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        write_d     = 1'b0;
        error_d     = error_q;
        idle_cnt_d  = idle_cnt_q;
        if (byte_valid || pstate_q == P_ADDR) idle_cnt_d = '0;
        else if (TIMEOUT_CLKS != 0)           idle_cnt_d = idle_cnt_q + 1'b1;

        if (frame_err) begin
            error_d  = 1'b1;
            pstate_d = P_ADDR;
        end else if (byte_valid) begin
            case (pstate_q)
                P_ADDR: begin
                    addr_d   = shift_q;
                    pstate_d = P_COUNT;
                end
                P_COUNT: begin
                    remaining_d = shift_q;
                    pstate_d    = (shift_q == 8'd0) ? P_ADDR : P_DATA;
                end
                default: begin   // P_DATA
                    data_d      = shift_q;
                    write_d     = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 8'd1) pstate_d = P_ADDR;
                end
            endcase
        end else if (timeout) begin
            pstate_d = P_ADDR;
        end
    end

    // parser state register
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q    <= P_ADDR;
            addr_q      <= '0;
            data_q      <= '0;
            remaining_q <= '0;
            write_q     <= 1'b0;
            error_q     <= 1'b0;
            idle_cnt_q  <= '0;
        end else begin
            pstate_q    <= pstate_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            write_q     <= write_d;
            error_q     <= error_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign data  = data_q;
    assign addr  = addr_q;
    assign write = write_q;
    assign error = error_q;
    assign state = pstate_q;
endmodule

// File: tb/tb_uart_packet_demux.sv
// Directed bench for uart_packet_demux; expected writes go into a scoreboard
// queue and a negedge monitor pops one per write strobe.
module tb_uart_packet_demux;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] data, addr;
    logic       write, error;
    logic [1:0] state;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    uart_packet_demux #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(200)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd),
        .data(data), .addr(addr), .write(write), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    // monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && write) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%02h data=%02h, none expected", addr, data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (addr !== e.addr || data !== e.data) begin
                    n_bad++;
                    $display("FAIL write: got addr=%02h data=%02h, want addr=%02h data=%02h",
                             addr, data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %02h, want %02h", name, got, want);
        end
    endtask

    // frame = start, 8 data LSB first, stop, then one idle bit time
    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(CPB);
        end
        uart_rxd = stop;
        tick(CPB);
        uart_rxd = 1'b1;
        tick(CPB);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        check(name, 8'(exp_q.size()), 8'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  data, 8'h00);
        check({tag, "_addr"},  addr, 8'h00);
        check({tag, "_write"}, {7'd0, write}, 8'h00);
        check({tag, "_error"}, {7'd0, error}, 8'h00);
        check({tag, "_state"}, {6'd0, state}, 8'h00);
    endtask

    initial begin
        tick(4);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(4);

        // single-byte packet
        expect_wr(8'h35, 8'hA5);
        send_byte(8'h35);
        send_byte(8'h01);
        send_byte(8'hA5);
        check_drained("t1_drained");
        check("t1_state", {6'd0, state}, 8'h00);

        // three-byte packet with state walk
        expect_wr(8'h37, 8'h4E);
        expect_wr(8'h37, 8'h45);
        expect_wr(8'h37, 8'h53);
        send_byte(8'h37);
        check("t2_state_count", {6'd0, state}, 8'h01);
        send_byte(8'h03);
        check("t2_state_data", {6'd0, state}, 8'h02);
        send_byte(8'h4E);
        send_byte(8'h45);
        check("t2_state_mid", {6'd0, state}, 8'h02);
        send_byte(8'h53);
        check_drained("t2_drained");
        check("t2_state_end", {6'd0, state}, 8'h00);

        // empty packet then single-byte packet
        send_byte(8'h40);
        send_byte(8'h00);
        check("t3_state_empty", {6'd0, state}, 8'h00);
        check("t3_addr_empty", addr, 8'h40);
        expect_wr(8'h41, 8'h80);
        send_byte(8'h41);
        send_byte(8'h01);
        send_byte(8'h80);
        check_drained("t3_drained");

        // one-clock glitch on the line must not produce a byte
        uart_rxd = 1'b0;
        tick(1);
        uart_rxd = 1'b1;
        tick(4 * CPB);
        check("t4_state_glitch", {6'd0, state}, 8'h00);
        check("t4_error_glitch", {7'd0, error}, 8'h00);
        expect_wr(8'h35, 8'h01);
        send_byte(8'h35);
        send_byte(8'h01);
        send_byte(8'h01);
        check_drained("t4_drained");
        check("t4_error", {7'd0, error}, 8'h00);

        // framing error mid-packet: sticky error, parser back to ADDR
        expect_wr(8'h37, 8'h11);
        send_byte(8'h37);
        send_byte(8'h02);
        send_byte(8'h11);
        check_drained("t5_drained");
        send_byte(8'h99, 1'b0);
        check("t5_error", {7'd0, error}, 8'h01);
        check("t5_state", {6'd0, state}, 8'h00);
        expect_wr(8'h35, 8'h00);
        send_byte(8'h35);
        send_byte(8'h01);
        send_byte(8'h00);
        check_drained("t5_drained2");
        check("t5_error_sticky", {7'd0, error}, 8'h01);

        // reset clears the sticky error
        reset = 1'b1;
        tick(2);
        check_reset_outputs("rst2");
        reset = 1'b0;
        tick(4);

        // timeout abandons a partial packet without flagging an error
        expect_wr(8'h37, 8'h22);
        send_byte(8'h37);
        send_byte(8'h05);
        send_byte(8'h22);
        check_drained("t6_drained");
        check("t6_state_before", {6'd0, state}, 8'h02);
        tick(250);
        check("t6_state_timeout", {6'd0, state}, 8'h00);
        check("t6_error_timeout", {7'd0, error}, 8'h00);
        expect_wr(8'h35, 8'h7F);
        send_byte(8'h35);
        send_byte(8'h01);
        send_byte(8'h7F);
        check_drained("t6_drained2");
        check("t6_addr", addr, 8'h35);
        check("t6_data", data, 8'h7F);
        check("t6_error", {7'd0, error}, 8'h00);

        // reset mid-byte while inside a packet
        send_byte(8'h36);
        uart_rxd = 1'b0;
        tick(3 * CPB);
        uart_rxd = 1'b1;
        reset = 1'b1;
        tick(2);
        check_reset_outputs("rst3");
        reset = 1'b0;
        tick(20 * CPB);
        check("rst3_state_after", {6'd0, state}, 8'h00);
        check_drained("final_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_packet_demux.md
Name: uart_packet_demux

Overview:
- Upstream feeder of the ROM loader and the host-control registers (loader config 0x35, joypad 0x40/0x41, loader data stream).
- Receives 8N1 serial bytes on the board RXD pin and parses them into framed packets: address byte, count byte, then payload bytes.
- Each payload byte is presented on data/addr with a one-cycle write strobe, which is the loader_clk / register-write interface consumed downstream.

Parameters:
- CLKS_PER_BIT, 186: system clocks per UART bit; 21.477 MHz / 115200 baud. Must be >= 4.
- TIMEOUT_CLKS, 2097152: idle clocks inside a packet before the parser abandons it and resyncs. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uart_rxd  in  1  asynchronous serial input, idle high
- data  out  8  current payload byte
- addr  out  8  address byte of the current packet
- write  out  1  one-cycle strobe; data/addr are valid while it is high
- error  out  1  sticky framing-error flag
- state  out  2  parser state, for debug: 0=ADDR, 1=COUNT, 2=DATA

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Reset values: data=0, addr=0, write=0, error=0, state=ADDR. Receiver returns to IDLE; all counters cleared.
- Reset mid-byte or mid-packet discards everything received so far.
- Input synchronizer: 2-flop synchronizer on uart_rxd, reset value 1. All sampling uses the synchronized value.
- Receiver FSM (IDLE, START, BITS, STOP):
  - IDLE -> START on synchronized rxd == 0; bit counter loaded with CLKS_PER_BIT/2 - 1.
  - START: at the mid-bit count, rxd still 0 -> BITS. rxd == 1 -> glitch: back to IDLE, no error.
  - BITS: 8 samples, one every CLKS_PER_BIT clocks, LSB first, shifted into the shift register.
  - STOP: sampled CLKS_PER_BIT after the last data bit.
    - rxd == 1: byte_valid pulses for exactly one cycle.
    - rxd == 0: framing error. Set error (sticky until reset), discard the byte, force parser to ADDR.
    - Either way, return to IDLE; the falling edge of the next start bit is honoured immediately.
- Parser FSM, advanced only on byte_valid:
  - ADDR: addr <= byte; -> COUNT.
  - COUNT: remaining <= byte. byte == 0 is an empty packet: -> ADDR, no write. Otherwise -> DATA.
  - DATA: data <= byte; write = 1 for the next cycle; remaining <= remaining - 1. When remaining was 1 -> ADDR.
- Write latency: write is high exactly one clk after the byte_valid cycle. data/addr update in that same edge and hold until the next write or a new ADDR byte.
- addr changes only on an ADDR byte. It is therefore stable for every write of a packet.
- Timeout: idle counter clears on every byte_valid and counts while parser != ADDR. Reaching TIMEOUT_CLKS forces parser to ADDR; error is not set.
- Simultaneous events:
  - reset has priority over everything.
  - A framing error and a timeout in the same cycle -> ADDR with error set.
- Width: remaining is 8 bits; the maximum packet is 255 payload bytes. The ROM loader streams larger images as repeated packets to the same address.
- Throughput: at most one write per 10*CLKS_PER_BIT clocks. There is no backpressure; the consumer must accept every strobe.

Test Plan:
- CLKS_PER_BIT=4, TIMEOUT_CLKS=200. Send 0x35, 0x01, 0xA5 -> exactly one write pulse with addr=0x35, data=0xA5. The pulse is one clk after the stop-bit sample. state ends at 0.
- Send 0x37, 0x03, 0x4E, 0x45, 0x53 -> three one-cycle writes: data 0x4E, 0x45, 0x53, all with addr=0x37. state sequence 0->1->2->0.
- Send 0x40, 0x00, then 0x41, 0x01, 0x80 -> no write for the empty packet; one write with addr=0x41, data=0x80.
- Drive rxd low for 1 clk only (glitch), then send a valid packet 0x35, 0x01, 0x01 -> no spurious byte; error=0; one write with data=0x01.
- Send 0x37, 0x02, 0x11, then a byte with stop bit 0 -> one write (0x11); error=1 and stays 1. Next valid packet 0x35, 0x01, 0x00 still writes with addr=0x35.
- Send 0x37, 0x05, 0x22, then idle for 250 clks, then 0x35, 0x01, 0x7F -> one write 0x22; timeout returns state to 0; second packet writes addr=0x35, data=0x7F; error=0. Assert reset mid-byte -> all outputs return to reset values.
